io_rail_pwr_seq: RTL and testbench
==================================

Name: io_rail_pwr_seq

Overview:
- Sequences power-up and power-down of the switched IO ring segments in the GF22FDX EG1 1.8 V IO ring.
- Each segment has a power-switch/rail-short enable and returns a power-good flag.
- Enables segments in order 0..N-1 on power-up and disables them in reverse order on power-down, with a programmable settle time per step.
- Monitors power-good, enforces a timeout, and collapses the whole ring to off on any fault. Sits in the always-on control domain next to the pad ring.

Parameters:
- N_SEG, 4, number of IO ring segments controlled.
- SETTLE_W, 8, width of the settle-count input.
- TIMEOUT_W, 12, width of the power-good timeout input.

Ports:
- clk_i  in  1  always-on control clock
- rst_i  in  1  asynchronous reset, active high
- pwr_up_req_i  in  1  level request to power the ring up
- pwr_dn_req_i  in  1  level request to power the ring down
- settle_cyc_i  in  SETTLE_W  settle cycles per step; sampled when the counter is loaded
- timeout_cyc_i  in  TIMEOUT_W  power-good wait limit; sampled when the counter is loaded
- clr_fault_i  in  1  clears FAULT and returns to OFF
- seg_pgood_i  in  N_SEG  per-segment power-good
- seg_en_o  out  N_SEG  per-segment switch enable
- busy_o  out  1  sequence in progress
- all_on_o  out  1  all segments up and good
- fault_o  out  1  sticky fault
- fault_seg_o  out  $clog2(N_SEG)  index of the faulting segment

Behaviour:
- Reset (asynchronous, active high): state OFF, idx 0, counter 0. All outputs 0: seg_en_o, busy_o, all_on_o, fault_o, fault_seg_o.
- All outputs are registered.
- busy_o = 1 in UP_EN, UP_SETTLE, UP_PG, DN_DIS, DN_SETTLE.
- all_on_o = 1 only in ON. fault_o = 1 only in FAULT.
- States and transitions:
  - OFF: pwr_up_req_i -> UP_EN with idx=0. pwr_dn_req_i is ignored.
  - UP_EN (1 cycle): set seg_en_o[idx]; load cnt=settle_cyc_i; -> UP_SETTLE.
  - UP_SETTLE: cnt decrements each cycle. At cnt==0, load cnt=timeout_cyc_i and go to UP_PG. With settle_cyc_i=0 the state lasts exactly one cycle.
  - UP_PG: if pgood[idx]=1 and idx==N_SEG-1 -> ON. If pgood[idx]=1 otherwise, idx++ and -> UP_EN. If pgood[idx]=0 with cnt==0 -> FAULT, fault_seg_o=idx. Otherwise cnt decrements.
  - ON: pwr_dn_req_i -> DN_DIS with idx=N_SEG-1. If any pgood bit drops -> FAULT, fault_seg_o = lowest low index. A pgood drop has priority over pwr_dn_req_i in the same cycle.
  - DN_DIS (1 cycle): clear seg_en_o[idx]; load cnt=settle_cyc_i; -> DN_SETTLE.
  - DN_SETTLE: at cnt==0, idx==0 -> OFF, otherwise idx-- and -> DN_DIS. Power-good is not checked on the way down.
  - FAULT: seg_en_o cleared to all-zero on entry. Requests are ignored. clr_fault_i -> OFF, with fault_seg_o cleared on exit.
- Abort: pwr_dn_req_i in any UP_* state -> DN_DIS with the current idx, so the sequence reverses from the highest enabled segment. The fault check in UP_PG has priority over the abort.
- Simultaneous requests: in OFF, up wins (down is meaningless there). Elsewhere, down wins.
- Up latency with pgood already high and settle S: S+3 cycles per segment. For N_SEG=4, S=2: ON is entered 20 cycles after the request is sampled.
- Down latency: S+2 cycles per segment.
- Requests are levels. A request held through completion causes no re-trigger: ON ignores up, OFF ignores down.

Optional Feature:
- Macro IO_PWR_SEQ_PGOOD_SYNC_EN.
- Defined: seg_pgood_i passes through a 2-flop synchronizer (reset to 0) before use. Every pgood response arrives 2 cycles later, including fault detection in ON.
- Undefined: seg_pgood_i is used directly and must be synchronous to clk_i.

Decomposition:
- Package io_pwr_seq_pkg holds:
  - the state enum (OFF, UP_EN, UP_SETTLE, UP_PG, ON, DN_DIS, DN_SETTLE, FAULT);
  - defaults for N_SEG, SETTLE_W, TIMEOUT_W;
  - a localparam idx width function.
- One sub-module, io_pwr_seq_sync: an N_SEG-wide 2-flop synchronizer with async reset. It is instantiated only under the macro.

Test Plan:
- Normal up: N_SEG=4, settle=2, pgood follows seg_en after 1 cycle, pulse up -> seg_en_o steps 0001, 0011, 0111, 1111; all_on_o=1 within 20–24 cycles; busy_o=0 in ON.
- Normal down from ON: settle=2, dn -> seg_en_o steps 0111, 0011, 0001, 0000, one step every 4 cycles; ends in OFF with all outputs 0.
- Timeout: timeout=5, segment 2 pgood stuck 0 -> FAULT 6 cycles after entering UP_PG; fault_seg_o=2; seg_en_o=0000; clr_fault_i -> OFF with fault_o=0.
- Abort: dn asserted during UP_SETTLE of segment 1 -> seg_en_o 0011 -> 0001 -> 0000 -> OFF; no fault.
- Fault in ON: drop seg_pgood_i[3] and [1] together -> FAULT, fault_seg_o=1, seg_en_o=0000. Simultaneous up+dn in OFF -> up sequence starts.
- Reset mid-sequence: rst_i asserted during UP_PG of segment 2 -> seg_en_o=0000 and all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/io_pwr_seq_pkg.sv
// Shared state encoding, parameter defaults and index-width helper for the IO ring power sequencer.
package io_pwr_seq_pkg;

    localparam int N_SEG_DEF     = 4;
    localparam int SETTLE_W_DEF  = 8;
    localparam int TIMEOUT_W_DEF = 12;

    typedef enum logic [2:0] {
        OFF,
        UP_EN,
        UP_SETTLE,
        UP_PG,
        ON,
        DN_DIS,
        DN_SETTLE,
        FAULT
    } seq_state_e;

    // Keeps a single-segment build from producing a zero-width index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_pwr_seq_sync.sv
// N_SEG-wide two-flop synchronizer for the pad-ring power-good flags.
module io_pwr_seq_sync
    import io_pwr_seq_pkg::*;
#(
    parameter int N_SEG = N_SEG_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_SEG-1:0] d_i,
    output logic [N_SEG-1:0] q_o
);

    logic [N_SEG-1:0] meta_p0;
    logic [N_SEG-1:0] sync_p1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            meta_p0 <= d_i;
            sync_p1 <= meta_p0;
        end
    end

    assign q_o = sync_p1;

endmodule

// File: rtl/io_rail_pwr_seq.sv
// IO ring segment power sequencer: ordered enable/disable with settle, pgood timeout and fault collapse.
// Define IO_PWR_SEQ_PGOOD_SYNC_EN to pass seg_pgood_i through a two-flop synchronizer.
module io_rail_pwr_seq
    import io_pwr_seq_pkg::*;
#(
    parameter int  N_SEG     = N_SEG_DEF,
    parameter int  SETTLE_W  = SETTLE_W_DEF,
    parameter int  TIMEOUT_W = TIMEOUT_W_DEF,
    localparam int IDX_W     = idx_w(N_SEG)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pwr_up_req_i,
    input  logic                 pwr_dn_req_i,
    input  logic [SETTLE_W-1:0]  settle_cyc_i,
    input  logic [TIMEOUT_W-1:0] timeout_cyc_i,
    input  logic                 clr_fault_i,
    input  logic [N_SEG-1:0]     seg_pgood_i,
    output logic [N_SEG-1:0]     seg_en_o,
    output logic                 busy_o,
    output logic                 all_on_o,
    output logic                 fault_o,
    output logic [IDX_W-1:0]     fault_seg_o
);

    localparam int               CNT_W = (SETTLE_W > TIMEOUT_W) ? SETTLE_W : TIMEOUT_W;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_SEG - 1);

    seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_SEG-1:0]  seg_en_q, seg_en_d;
    logic [IDX_W-1:0]  fault_seg_q, fault_seg_d;
    logic              busy_q, all_on_q, fault_q;
    logic              busy_d, all_on_d, fault_d;
    logic [N_SEG-1:0]  pgood;
    logic [IDX_W-1:0]  low_idx;

`ifdef IO_PWR_SEQ_PGOOD_SYNC_EN
    io_pwr_seq_sync #(
        .N_SEG (N_SEG)
    ) u_pgood_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (seg_pgood_i),
        .q_o   (pgood)
    );
`else
    assign pgood = seg_pgood_i;
`endif

    // Lowest segment whose power-good is low; used when ON collapses.
    always_comb begin
        low_idx = '0;
        for (int i = N_SEG - 1; i >= 0; i--) begin
            if (!pgood[i]) low_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        seg_en_d    = seg_en_q;
        fault_seg_d = fault_seg_q;
        unique case (state_q)
            OFF: begin
                if (pwr_up_req_i) begin
                    state_d = UP_EN;
                    idx_d   = '0;
                end
            end
            UP_EN: begin
                if (pwr_dn_req_i) begin
                    state_d = DN_DIS;
                end else begin
                    seg_en_d[idx_q] = 1'b1;
                    cnt_d           = CNT_W'(settle_cyc_i);
                    state_d         = UP_SETTLE;
                end
            end
            UP_SETTLE: begin
                if (pwr_dn_req_i) begin
                    state_d = DN_DIS;
                end else if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(timeout_cyc_i);
                    state_d = UP_PG;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            UP_PG: begin
                // A timed-out segment faults even if an abort arrives in the same cycle.
                if (!pgood[idx_q] && cnt_q == '0) begin
                    state_d     = FAULT;
                    seg_en_d    = '0;
                    fault_seg_d = idx_q;
                end else if (pwr_dn_req_i) begin
                    state_d = DN_DIS;
                end else if (pgood[idx_q]) begin
                    if (idx_q == LAST) begin
                        state_d = ON;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = UP_EN;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ON: begin
                if (pgood != '1) begin
                    state_d     = FAULT;
                    seg_en_d    = '0;
                    fault_seg_d = low_idx;
                end else if (pwr_dn_req_i) begin
                    state_d = DN_DIS;
                    idx_d   = LAST;
                end
            end
            DN_DIS: begin
                seg_en_d[idx_q] = 1'b0;
                cnt_d           = CNT_W'(settle_cyc_i);
                state_d         = DN_SETTLE;
            end
            DN_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (idx_q == '0) begin
                    state_d = OFF;
                end else begin
                    idx_d   = idx_q - IDX_W'(1);
                    state_d = DN_DIS;
                end
            end
            FAULT: begin
                if (clr_fault_i) begin
                    state_d     = OFF;
                    fault_seg_d = '0;
                end
            end
            default: state_d = OFF;
        endcase
    end

    // Status flags are decoded from the next state so they register alongside it.
    assign busy_d   = state_d inside {UP_EN, UP_SETTLE, UP_PG, DN_DIS, DN_SETTLE};
    assign all_on_d = (state_d == ON);
    assign fault_d  = (state_d == FAULT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= OFF;
            idx_q       <= '0;
            cnt_q       <= '0;
            seg_en_q    <= '0;
            fault_seg_q <= '0;
            busy_q      <= 1'b0;
            all_on_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            seg_en_q    <= seg_en_d;
            fault_seg_q <= fault_seg_d;
            busy_q      <= busy_d;
            all_on_q    <= all_on_d;
            fault_q     <= fault_d;
        end
    end

    assign seg_en_o    = seg_en_q;
    assign busy_o      = busy_q;
    assign all_on_o    = all_on_q;
    assign fault_o     = fault_q;
    assign fault_seg_o = fault_seg_q;

endmodule

// File: tb/tb_io_rail_pwr_seq.sv
// Bench for io_rail_pwr_seq: directed and randomized sequences against a timeline model of the ring.
module tb_io_rail_pwr_seq;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         up;
    logic         dn;
    logic [7:0]   settle;
    logic [11:0]  tmo;
    logic         clr;
    logic [N-1:0] pgood;
    logic [N-1:0] seg_en;
    logic         busy;
    logic         all_on;
    logic         fault;
    logic [1:0]   fseg;

    logic [N-1:0] stuck;
    logic [N-1:0] drop;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    io_rail_pwr_seq #(
        .N_SEG     (N),
        .SETTLE_W  (8),
        .TIMEOUT_W (12)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pwr_up_req_i  (up),
        .pwr_dn_req_i  (dn),
        .settle_cyc_i  (settle),
        .timeout_cyc_i (tmo),
        .clr_fault_i   (clr),
        .seg_pgood_i   (pgood),
        .seg_en_o      (seg_en),
        .busy_o        (busy),
        .all_on_o      (all_on),
        .fault_o       (fault),
        .fault_seg_o   (fseg)
    );

    // Pad model: a segment reports good one cycle after its enable, unless stuck or dropped.
    task automatic upd_pg();
        pgood = seg_en & ~stuck & ~drop;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        upd_pg();
    endtask

    task automatic chk(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {seg_en, busy, all_on, fault, fseg};
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed en=%b busy=%b on=%b flt=%b seg=%0d, expected en=%b busy=%b on=%b flt=%b seg=%0d",
                   tag, obs[8:5], obs[4], obs[3], obs[2], obs[1:0],
                   exp[8:5], exp[4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    function automatic logic [8:0] pk(input logic [N-1:0] en, input logic b, input logic a,
                                      input logic f, input int s);
        return {en, b, a, f, 2'(s)};
    endfunction

    // Segments 0..last whose enable step (period p, one cycle after UP_EN) has happened by cycle t.
    function automatic logic [N-1:0] up_mask(input int t, input int p, input int last);
        logic [N-1:0] m;
        m = '0;
        for (int k = 0; k < N; k++) begin
            if (k <= last && k * p + 1 <= t) m[k] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [N-1:0] keep_below(input logic [N-1:0] m, input int top);
        logic [N-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (k < top) r[k] = m[k];
        end
        return r;
    endfunction

    // Number of disable steps (period q) completed by cycle t, out of n.
    function automatic int n_steps(input int t, input int q, input int n);
        int c;
        c = 0;
        for (int j = 0; j < n; j++) begin
            if (j * q + 1 <= t) c++;
        end
        return c;
    endfunction

    function automatic int lowest(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            if (m[k]) return k;
        end
        return 0;
    endfunction

    task automatic bring_up(input int s, input bit both);
        int p;
        p      = s + 3;
        settle = 8'(s);
        tmo    = 12'd8;
        up     = 1'b1;
        dn     = both;
        for (int t = 0; t <= N * p + 2; t++) begin
            tick();
            if (t == 0) dn = 1'b0;
            chk("up_seq", pk(up_mask(t, p, N - 1), t < N * p, t >= N * p, 1'b0, 0));
        end
        up = 1'b0;
    endtask

    task automatic bring_down(input int s);
        int q;
        int cl;
        q      = s + 2;
        settle = 8'(s);
        dn     = 1'b1;
        for (int t = 0; t <= N * q + 2; t++) begin
            tick();
            cl = n_steps(t, q, N);
            chk("dn_seq", pk(keep_below('1, N - cl), t < N * q, 1'b0, 1'b0, 0));
        end
        dn = 1'b0;
    endtask

    task automatic timeout_run(input int s, input int tv, input int seg);
        int p;
        int f;
        p      = s + 3;
        f      = seg * p + s + 3 + tv;
        settle = 8'(s);
        tmo    = 12'(tv);
        stuck  = 4'(1 << seg);
        up     = 1'b1;
        for (int t = 0; t <= f; t++) begin
            tick();
            if (t < f) chk("tmo_seq", pk(up_mask(t, p, seg), 1'b1, 1'b0, 1'b0, 0));
            else       chk("tmo_fault", pk('0, 1'b0, 1'b0, 1'b1, seg));
        end
        dn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fault_hold", pk('0, 1'b0, 1'b0, 1'b1, seg));
        end
        clr = 1'b1;
        up  = 1'b0;
        dn  = 1'b0;
        tick();
        chk("fault_clr", pk('0, 1'b0, 1'b0, 1'b0, 0));
        clr   = 1'b0;
        stuck = '0;
    endtask

    task automatic abort_run(input int s, input int a);
        int p;
        int q;
        int k;
        int cl;
        logic [N-1:0] m0;
        p      = s + 3;
        q      = s + 2;
        k      = (a - 1) / p;
        m0     = up_mask(a - 1, p, N - 1);
        settle = 8'(s);
        tmo    = 12'd8;
        up     = 1'b1;
        for (int t = 0; t < a; t++) begin
            tick();
            if (t == 0) up = 1'b0;
            chk("abort_up", pk(up_mask(t, p, N - 1), 1'b1, 1'b0, 1'b0, 0));
        end
        dn = 1'b1;
        for (int t = 0; t <= (k + 1) * q + 2; t++) begin
            tick();
            cl = n_steps(t, q, k + 1);
            chk("abort_dn", pk(keep_below(m0, k + 1 - cl), t < (k + 1) * q, 1'b0, 1'b0, 0));
        end
        dn = 1'b0;
    endtask

    task automatic on_fault_run(input int s, input logic [N-1:0] dmask);
        bring_up(s, 1'b0);
        drop = dmask;
        upd_pg();
        dn = 1'b1;
        tick();
        chk("on_fault", pk('0, 1'b0, 1'b0, 1'b1, lowest(dmask)));
        tick();
        chk("on_fault_hold", pk('0, 1'b0, 1'b0, 1'b1, lowest(dmask)));
        clr = 1'b1;
        dn  = 1'b0;
        tick();
        chk("on_fault_clr", pk('0, 1'b0, 1'b0, 1'b0, 0));
        clr  = 1'b0;
        drop = '0;
    endtask

    task automatic reset_mid_run(input int s);
        int p;
        p      = s + 3;
        settle = 8'(s);
        tmo    = 12'd8;
        up     = 1'b1;
        for (int t = 0; t <= 2 * p + s + 2; t++) begin
            tick();
            chk("rst_pre", pk(up_mask(t, p, N - 1), 1'b1, 1'b0, 1'b0, 0));
        end
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", pk('0, 1'b0, 1'b0, 1'b0, 0));
        up = 1'b0;
        tick();
        chk("rst_hold", pk('0, 1'b0, 1'b0, 1'b0, 0));
        rst = 1'b0;
        tick();
        chk("rst_off", pk('0, 1'b0, 1'b0, 1'b0, 0));
    endtask

    initial begin
        rst    = 1'b1;
        up     = 1'b0;
        dn     = 1'b0;
        clr    = 1'b0;
        settle = 8'd2;
        tmo    = 12'd8;
        stuck  = '0;
        drop   = '0;
        pgood  = '0;
        tick();
        chk("reset", pk('0, 1'b0, 1'b0, 1'b0, 0));
        tick();
        rst = 1'b0;
        dn  = 1'b1;
        tick();
        chk("off_ignores_dn", pk('0, 1'b0, 1'b0, 1'b0, 0));
        dn = 1'b0;

        bring_up(2, 1'b0);
        bring_down(2);
        bring_up(int'($urandom_range(0, 6)), 1'b1);
        bring_down(int'($urandom_range(0, 6)));

        timeout_run(2, 5, 2);
        for (int i = 0; i < 3; i++) begin
            timeout_run(int'($urandom_range(0, 4)), int'($urandom_range(0, 12)), int'($urandom_range(0, N - 1)));
        end

        abort_run(2, 2 + 3 + 2);
        for (int i = 0; i < 4; i++) begin
            int s;
            s = int'($urandom_range(0, 4));
            abort_run(s, int'($urandom_range(1, N * (s + 3))));
        end

        on_fault_run(2, 4'b1010);
        on_fault_run(int'($urandom_range(0, 4)), 4'(($urandom_range(1, 15))));

        reset_mid_run(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected completion before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
